// File: rtl/aes_round_ctrl_if.sv
// Plaintext-in / ciphertext-out handshake bundle for aes_round_ctrl.
interface aes_round_ctrl_if #(parameter int W = 128);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer and state register; the SubBytes/ShiftRows/
// MixColumns chain and key store are external and combinational.
module aes_round_ctrl #(
   parameter int NR = 10,
   parameter int W  = 128
) (
   input  logic             clk,
   input  logic             rst,
   aes_round_ctrl_if.slave  bus,
   output logic [W-1:0]     state_out,
   input  logic [W-1:0]     mix_in,
   input  logic [W-1:0]     sr_in,
   output logic [3:0]       rk_idx,
   input  logic [W-1:0]     rk_in,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

   localparam logic [3:0] LAST = 4'(NR);

   fsm_e         fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [W-1:0] state_q, state_d;
   logic         out_valid_q;
   logic         busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         round_q     <= '0;
         state_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         round_q     <= round_d;
         state_q     <= state_d;
         out_valid_q <= (fsm_d == DONE);
         busy_q      <= (fsm_d != IDLE);
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      case (fsm_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = bus.in_data ^ rk_in;
               round_d = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            // Final round skips MixColumns, so take the ShiftRows tap instead.
            if (round_q == LAST) begin
               state_d = sr_in ^ rk_in;
               round_d = '0;
               fsm_d   = DONE;
            end else begin
               state_d = mix_in ^ rk_in;
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) fsm_d = IDLE;
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.in_ready  = (fsm_q == IDLE) && !rst;
      rk_idx        = (fsm_q == ROUND) ? round_q : '0;
      bus.out_valid = out_valid_q;
      bus.out_data  = state_q;
      state_out     = state_q;
      busy          = busy_q;
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl; a behavioural AES chain and key store close the loop.
module tb_aes_round_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] state_out, mix_in, sr_in, rk_in;
   logic [3:0]   rk_idx;
   logic         busy;
   logic [127:0] rk_tab [2][16];
   int           key_sel;
   int           n_assert = 0;
   int           n_fail   = 0;

   logic [127:0] key_b, pt_b, ct_b, key_c, pt_c, ct_c;

   aes_round_ctrl_if #(.W(128)) bus ();

   aes_round_ctrl #(.NR(10), .W(128)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_out (state_out),
      .mix_in    (mix_in),
      .sr_in     (sr_in),
      .rk_idx    (rk_idx),
      .rk_in     (rk_in),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // a^254 is the field inverse (and maps 0 to 0).
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq = a;
      logic [7:0] r  = 8'h01;
      logic [7:0] b;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];
         a1 = s[32*c+8 +: 8];
         a2 = s[32*c+16 +: 8];
         a3 = s[32*c+24 +: 8];
         o[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] bswap(input logic [127:0] v);
      logic [127:0] o;
      for (int k = 0; k < 16; k++) o[8*k +: 8] = v[8*(15-k) +: 8];
      return o;
   endfunction

   task automatic expand_key(input logic [127:0] key, input int sel);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {24'h0, rc};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rk_tab[sel][r] = (r <= 10) ? {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]} : '0;
   endtask

   always_comb begin
      sr_in  = sub_shift(state_out);
      mix_in = mix_cols(sr_in);
      rk_in  = rk_tab[key_sel][rk_idx];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge with the controller idle; returns idle after the out handshake.
   task automatic encrypt(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct,
                          input int stall, input bit pulse, input string tag);
      chk({tag, "_idle_ready"}, 128'(bus.in_ready), 128'd1);
      chk({tag, "_rk0"}, 128'(rk_idx), 128'd0);
      bus.in_valid  = 1'b1;
      bus.in_data   = pt;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, "_ark0"}, state_out, pt ^ key);
      for (int k = 1; k <= 10; k++) begin
         chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(k));
         chk({tag, "_early_valid"}, 128'(bus.out_valid), 128'd0);
         chk({tag, "_busy"}, 128'(busy), 128'd1);
         chk({tag, "_ready_round"}, 128'(bus.in_ready), 128'd0);
         bus.in_valid = (pulse && k == 4);
         bus.in_data  = ~pt;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
      chk({tag, "_ct"}, bus.out_data, ct);
      chk({tag, "_state_out"}, state_out, ct);
      chk({tag, "_rk_done"}, 128'(rk_idx), 128'd0);
      chk({tag, "_ready_done"}, 128'(bus.in_ready), 128'd0);
      for (int s = 0; s < stall; s++) begin
         bus.in_valid = (pulse && s == 0);
         @(negedge clk);
         chk({tag, "_stall_valid"}, 128'(bus.out_valid), 128'd1);
         chk({tag, "_stall_ct"}, bus.out_data, ct);
         chk({tag, "_stall_ready"}, 128'(bus.in_ready), 128'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_post_valid"}, 128'(bus.out_valid), 128'd0);
      chk({tag, "_post_ready"}, 128'(bus.in_ready), 128'd1);
      chk({tag, "_post_busy"}, 128'(busy), 128'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      key_b = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
      pt_b  = bswap(128'h3243f6a8885a308d313198a2e0370734);
      ct_b  = bswap(128'h3925841d02dc09fbdc118597196a0b32);
      key_c = bswap(128'h000102030405060708090a0b0c0d0e0f);
      pt_c  = bswap(128'h00112233445566778899aabbccddeeff);
      ct_c  = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      expand_key(key_b, 0);
      expand_key(key_c, 1);
      key_sel       = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_state", state_out, 128'd0);
      chk("rst_rk_idx", 128'(rk_idx), 128'd0);
      rst = 1'b0;
      @(negedge clk);

      key_sel = 0;
      encrypt(pt_b, key_b, ct_b, 0, 1'b0, "fips_b");

      key_sel = 1;
      encrypt(pt_c, key_c, ct_c, 7, 1'b0, "fips_c");

      // Back-to-back: in_valid and out_ready held high across two blocks.
      key_sel       = 0;
      bus.in_valid  = 1'b1;
      bus.in_data   = pt_b;
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         chk("b2b_first_valid", 128'(bus.out_valid), 128'(k == 11));
      end
      chk("b2b_first_ct", bus.out_data, ct_b);
      key_sel     = 1;
      bus.in_data = pt_c;
      @(negedge clk);
      chk("b2b_gap_valid", 128'(bus.out_valid), 128'd0);
      chk("b2b_gap_ready", 128'(bus.in_ready), 128'd1);
      @(negedge clk);
      chk("b2b_second_accept", 128'(rk_idx), 128'd1);
      chk("b2b_second_busy", 128'(busy), 128'd1);
      for (int k = 14; k <= 23; k++) begin
         @(negedge clk);
         chk("b2b_second_valid", 128'(bus.out_valid), 128'(k == 23));
      end
      chk("b2b_second_ct", bus.out_data, ct_c);
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("b2b_end_valid", 128'(bus.out_valid), 128'd0);
      chk("b2b_end_ready", 128'(bus.in_ready), 128'd1);

      // Reset with round counter at 5.
      key_sel      = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = pt_b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_round5", 128'(rk_idx), 128'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_busy", 128'(busy), 128'd0);
      chk("mid_state", state_out, 128'd0);
      chk("mid_valid", 128'(bus.out_valid), 128'd0);
      chk("mid_ready", 128'(bus.in_ready), 128'd0);
      chk("mid_rk_idx", 128'(rk_idx), 128'd0);
      rst = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         chk("mid_no_valid", 128'(bus.out_valid), 128'd0);
      end
      encrypt(pt_b, key_b, ct_b, 0, 1'b0, "after_rst");

      key_sel = 1;
      encrypt(pt_c, key_c, ct_c, 3, 1'b1, "pulse");
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk("pulse_single_valid", 128'(bus.out_valid), 128'd0);
         chk("pulse_single_busy", 128'(busy), 128'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 round controller and state register that sits directly downstream of the MixColumns stage.
- Holds the 128-bit AES state and drives it into the combinational SubBytes -> ShiftRows -> MixColumns chain.
- Each cycle it consumes the MixColumns result (or the ShiftRows result in the final round), applies AddRoundKey and re-registers the state.
- Sequences the initial AddRoundKey plus NR rounds, and fronts the datapath with valid/ready handshakes for input and output.

Parameters:
NR, 10, number of AES rounds (10 for AES-128); legal range 1..15
W, 128, state/key width in bits; fixed at 128, not to be overridden

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext block on in_data is valid
in_ready  output  1  controller can accept a block (IDLE only)
in_data  input  128  plaintext; byte k = bits [8k+7:8k]; column c = bytes 4c..4c+3
state_out  output  128  current state register, feeds SubBytes chain
mix_in  input  128  MixColumns(ShiftRows(SubBytes(state_out))), combinational return
sr_in  input  128  ShiftRows(SubBytes(state_out)), combinational return, final round
rk_idx  output  4  round key index requested from key store
rk_in  input  128  round key for rk_idx, combinational, same cycle
out_valid  output  1  ciphertext on out_data is valid
out_ready  input  1  downstream accepts ciphertext
out_data  output  128  ciphertext (equals state register in DONE)
busy  output  1  high in ROUND or DONE

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high; it takes precedence over every other input on the same edge.
- Reset values: FSM=IDLE, state=0, round=0, out_valid=0, busy=0. While rst=1, in_ready is forced to 0. rk_idx=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On an edge with in_valid=1: state <= in_data ^ rk_in (initial AddRoundKey), round <= 1, go to ROUND.
  - Otherwise hold; state keeps its last value.
- ROUND:
  - in_ready=0, rk_idx=round.
  - Each edge: if round<NR, state <= mix_in ^ rk_in, round <= round+1.
  - If round==NR, state <= sr_in ^ rk_in (no MixColumns), round <= 0, go to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid=1, out_data=state, rk_idx=0, in_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE.
  - Otherwise hold; out_data is stable while stalled.
- Latency: exactly NR+1 edges from the accept edge (in_valid & in_ready) to the first cycle with out_valid=1. For NR=10, out_valid is high in the cycle after the 11th edge.
- Throughput: one block per NR+2 cycles minimum. No overlap: a new block is accepted no earlier than the cycle after the out handshake.
- Round counter: 4 bits. It never exceeds NR and does not wrap; at NR it resets to 0.
- out_valid and busy are registered. in_ready and rk_idx are combinational from FSM/round only, never from other inputs.
- state_out always equals the state register, including during IDLE and DONE.
- Reset mid-operation (ROUND or DONE): the block is discarded, all registers return to reset values, and no out_valid pulse occurs.
- in_valid held high through a whole operation does not cause a re-accept until IDLE is re-entered.
- The key store must present rk_in for rk_idx in the same cycle. The controller never registers rk_in.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 (first FIPS byte = byte 0) -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 edges after accept.
- FIPS-197 App. C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a; rk_idx sequence 0,1,..,10 on successive cycles.
- Backpressure: hold out_ready=0 for 7 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready=0; release -> IDLE next edge, in_ready=1.
- Back-to-back: in_valid tied 1 with two vectors, out_ready tied 1 -> second accept occurs the cycle after the first out handshake; both ciphertexts correct; period 12 cycles.
- Reset at round 5 -> next cycle FSM=IDLE, state=0, busy=0, out_valid never asserted; a subsequent block still encrypts correctly.
- in_valid pulsed during ROUND and DONE -> ignored; exactly one ciphertext produced.
